txgen: RTL

- Bus data generation block: the transmit-side counterpart of the bus receive parser.
- Accepts a one-cycle return-command request (ret_cmd + ret_cmd_flg) plus a payload snapshot.
- Builds a framed response: header, cmd, length, payload, checksum.
- Streams the frame one byte at a time to the bus byte transmitter using a flag/done handshake.

---
 rtl/txgen_if.sv | 26 ++
 rtl/txgen.sv | 122 ++++++++++++
 2 files changed

// File: rtl/txgen_if.sv
// rtl/txgen_if.sv - request and byte-transmitter handshake bundle for txgen
interface txgen_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
);
  logic [7:0]           ret_cmd;
  logic                 ret_cmd_flg;
  logic [LEN_W-1:0]     ret_len;
  logic [8*MAX_LEN-1:0] ret_payload;
  logic [7:0]           tx_data;
  logic                 tx_flag;
  logic                 tx_done;
  logic                 busy;
  logic                 cmd_drop;
  logic                 tx_err;

  modport master (
    output ret_cmd, ret_cmd_flg, ret_len, ret_payload, tx_done,
    input  tx_data, tx_flag, busy, cmd_drop, tx_err
  );

  modport slave (
    input  ret_cmd, ret_cmd_flg, ret_len, ret_payload, tx_done,
    output tx_data, tx_flag, busy, cmd_drop, tx_err
  );
endinterface

// File: rtl/txgen.sv
// rtl/txgen.sv - frames a return command (hdr, cmd, len, payload, sum) and streams it byte by byte
module txgen #(
  parameter int          MAX_LEN = 8,
  parameter int          LEN_W   = 4,
  parameter logic [7:0]  HDR0    = 8'h55,
  parameter logic [7:0]  HDR1    = 8'hAA,
  parameter logic [19:0] TO_CYC  = 20'd100000
) (
  input  logic  sys_clk,
  input  logic  sys_rst,
  txgen_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_CMD, S_LEN, S_DATA, S_SUM
  } state_t;

  state_t               state, state_d;
  logic                 issue, issue_d;
  logic [LEN_W-1:0]     idx, idx_d, len_q, len_clamped;
  logic [7:0]           cmd_q, sum_q, data_q, byte_d;
  logic [8*MAX_LEN-1:0] pay_q;
  logic [19:0]          wait_cnt;
  logic                 timeout, accept, drop_q, err_q;

  assign accept      = (state == S_IDLE) && bus.ret_cmd_flg;
  assign len_clamped = (bus.ret_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.ret_len;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state    <= S_IDLE;
      issue    <= 1'b0;
      idx      <= '0;
      len_q    <= '0;
      cmd_q    <= '0;
      sum_q    <= '0;
      data_q   <= '0;
      pay_q    <= '0;
      wait_cnt <= '0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_d;
      issue  <= issue_d;
      idx    <= idx_d;
      drop_q <= bus.ret_cmd_flg && (state != S_IDLE);
      err_q  <= timeout;
      if (accept) begin
        cmd_q <= bus.ret_cmd;
        len_q <= len_clamped;
        pay_q <= bus.ret_payload;
      end
      // Checksum covers cmd, len and payload as each is issued; headers are excluded.
      if (accept)
        sum_q <= '0;
      else if (issue_d && (state_d == S_CMD || state_d == S_LEN || state_d == S_DATA))
        sum_q <= sum_q + byte_d;
      if (issue_d)
        data_q <= byte_d;
      if (issue_d || state_d == S_IDLE)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 20'd1;
    end
  end

  always_comb begin
    state_d = state;
    issue_d = 1'b0;
    idx_d   = idx;
    timeout = 1'b0;
    if (state == S_IDLE) begin
      if (bus.ret_cmd_flg) begin
        state_d = S_HDR0;
        issue_d = 1'b1;
      end
    end else if (!issue) begin
      // tx_done is honoured only in the wait phase.
      if (bus.tx_done) begin
        issue_d = 1'b1;
        case (state)
          S_HDR0: state_d = S_HDR1;
          S_HDR1: state_d = S_CMD;
          S_CMD:  state_d = S_LEN;
          S_LEN: begin
            idx_d   = '0;
            state_d = (len_q != '0) ? S_DATA : S_SUM;
          end
          S_DATA: begin
            if (idx == len_q - 1'b1) state_d = S_SUM;
            else                     idx_d   = idx + 1'b1;
          end
          default: begin
            state_d = S_IDLE;
            issue_d = 1'b0;
          end
        endcase
      end else if (wait_cnt == TO_CYC - 20'd1) begin
        state_d = S_IDLE;
        timeout = 1'b1;
      end
    end
  end

  always_comb begin
    bus.tx_flag  = issue;
    bus.tx_data  = data_q;
    bus.busy     = (state != S_IDLE);
    bus.cmd_drop = drop_q;
    bus.tx_err   = err_q;
    case (state_d)
      S_HDR0:  byte_d = HDR0;
      S_HDR1:  byte_d = HDR1;
      S_CMD:   byte_d = cmd_q;
      S_LEN:   byte_d = 8'(len_q);
      S_DATA:  byte_d = pay_q[{idx_d, 3'b000} +: 8];
      S_SUM:   byte_d = sum_q;
      default: byte_d = 8'h00;
    endcase
  end

endmodule
